led_mem_rsp: RTL
================

LED_MEM_RSP -- requirements
Module: led_mem_rsp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: the word width.
REQ-002 The block SHALL have parameter ADDR_W, default 4: the address width, giving a depth of 2^ADDR_W = 16 words.
REQ-003 The block SHALL have parameter INIT_VAL, default 16'h0000: the value written to every word by the clear sweep.
REQ-004 The block SHALL have port clk_g  input  1: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-006 The block SHALL have port ena  input  1: access enable from the initiator.
REQ-007 The block SHALL have port wea  input  1: write enable, qualified by ena.
REQ-008 The block SHALL have port addra  input  ADDR_W: word address.
REQ-009 The block SHALL have port dina  input  DATA_W: write data.
REQ-010 The block SHALL have port douta  output  DATA_W: read data.
REQ-011 The block SHALL have port busy  output  1: high while the clear sweep runs; accesses are ignored while high.

Function
REQ-012 The block SHALL implement a single-port synchronous RAM of 2^ADDR_W x DATA_W words, acting as the responder to the memory_w_r-style initiator.
REQ-013 The FSM SHALL have exactly two states: CLEAR and READY.
REQ-014 In CLEAR, a sweep counter running 0..2^ADDR_W-1 SHALL write INIT_VAL to one word per cycle.
REQ-015 The FSM SHALL move to READY on the cycle after address 2^ADDR_W-1 is written; the sweep SHALL last exactly 16 cycles at default parameters.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-017 While in CLEAR, ena, wea, addra and dina SHALL be ignored, and douta SHALL hold 0.
REQ-018 In READY, a read (ena=1, wea=0 at edge N) SHALL present mem[addra] on douta after edge N; read latency is 1 cycle.
REQ-019 In READY, a write (ena=1, wea=1 at edge N) SHALL set mem[addra] to dina at edge N and SHALL present dina on douta after edge N (write-first).
REQ-020 When ena=0, the memory SHALL be unchanged and douta SHALL hold its previous value.
REQ-021 Back-to-back accesses SHALL be accepted every cycle with no bubbles.
REQ-022 A read of an address written on the previous cycle SHALL return the new data.
REQ-023 Address values SHALL wrap naturally within ADDR_W bits; no out-of-range case exists.
REQ-024 wea with ena=0 SHALL have no effect.

Reset
REQ-025 Asserting rst SHALL immediately, without waiting for a clock edge, set douta=0, busy=1, FSM=CLEAR and sweep counter=0.
REQ-026 The memory array itself SHALL NOT be asynchronously reset; its contents SHALL be initialised only by the sweep.
REQ-027 The sweep SHALL start on the first clk_g edge after rst deasserts.
REQ-028 Asserting rst mid-sweep or mid-access SHALL abort the operation and restart the sweep from address 0 after release.

Configuration
REQ-029 The macro LED_MEM_DOUT_REG_EN SHALL select the output register option.
REQ-030 When LED_MEM_DOUT_REG_EN is defined, an extra output register SHALL be inserted after the RAM read stage, making read and write-echo latency 2 cycles.
REQ-031 With LED_MEM_DOUT_REG_EN defined, the extra register SHALL reset to 0 asynchronously, update every cycle, and follow the hold rule of REQ-020 one cycle later.
REQ-032 When LED_MEM_DOUT_REG_EN is undefined, latency SHALL be 1 cycle and the extra register SHALL not exist.
REQ-033 busy timing SHALL be identical with and without LED_MEM_DOUT_REG_EN.

Verification
REQ-034 Release rst, count busy cycles, then read all 16 addresses -> busy high exactly 16 cycles; every read returns 16'h0000.
REQ-035 In READY, write 16'h0001<<i to address i for i=0..15, then read back 0..15 -> douta=16'h0001<<i, one cycle after each read (two cycles with the macro defined).
REQ-036 Write 16'hA5A5 to address 3, read address 3 on the next cycle -> douta=16'hA5A5 on the write-echo cycle and on the read cycle.
REQ-037 Drive ena=1, wea=1, addra=5, dina=16'hFFFF during CLEAR -> after the sweep, a read of address 5 returns 16'h0000.
REQ-038 Write 16'h1234 to address 7, then hold ena=0 for 4 cycles -> douta stays 16'h1234.
REQ-039 Assert rst at sweep address 8, release it -> douta=0 immediately, busy=1 for a full 16 cycles again, and all words read 16'h0000.

Source files
------------

// File: rtl/led_mem_rsp.sv
// Single-port RAM responder with a power-up clear sweep; busy is high until every word holds INIT_VAL.
// Optional LED_MEM_DOUT_REG_EN adds a second output register (latency 2 instead of 1).
module led_mem_rsp #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 4,
  parameter logic [DATA_W-1:0]  INIT_VAL = 16'h0000
) (
  input  logic              clk_g,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              dbg_state_o
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Handshake: an access is offered when ena=1 and taken at that rising edge
  // only if busy=0; there is no stall once READY, one access per cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = INIT_VAL;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        dout_d = '0;
        if (cnt_q == LAST) state_d = READY;
      end
      READY: begin
        if (ena) begin
          if (wea) begin
            mem_we    = 1'b1;
            mem_waddr = addra;
            mem_wdata = dina;
            dout_d    = dina;
          end else begin
            dout_d = mem_q[addra];
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Array has no reset; its contents come only from the sweep.
  always_ff @(posedge clk_g) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef LED_MEM_DOUT_REG_EN
  logic [DATA_W-1:0] dout_pipe_q;

  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) dout_pipe_q <= '0;
    else     dout_pipe_q <= dout_q;
  end

  assign douta = dout_pipe_q;
`else
  assign douta = dout_q;
`endif

  assign busy        = (state_q == CLEAR);
  assign dbg_state_o = (state_q == READY);

endmodule
